// File: rtl/alu_calc_core.sv
// Button-driven operand entry (A/B with auto-repeat) feeding a registered ALU, with accumulate into A.
// Latency: input edge -> operand write 2 cycles after sync; operand/op change -> c/co/zero 1 cycle later.
// Backpressure: none; events are applied unconditionally, res_valid is a single-cycle strobe.
module alu_calc_core #(
  parameter int unsigned WIDTH      = 4,
  parameter logic [23:0] HOLD_CYC   = 24'd5000000,
  parameter logic [23:0] REPEAT_CYC = 24'd2500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       btn,
  input  logic [1:0]       dir,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             acc_btn,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             co,
  output logic             zero,
  output logic             res_valid
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Channel 0 = btn[0] (A), channel 1 = btn[1] (B), channel 2 = acc_btn.
  logic [2:0]        s1;
  logic [2:0]        s2;
  logic [2:0]        prev;
  logic [2:0]        press;

  // Auto-repeat state for the two operand buttons only.
  logic [1:0][23:0]  cnt;
  logic [1:0]        rpt;
  logic [1:0]        fire;
  logic [1:0]        evt;

  logic              acc_fire;
  logic              a_wr;
  logic              b_wr;
  logic              wr_q;
  logic [WIDTH-1:0]  a_nxt;
  logic [WIDTH-1:0]  b_nxt;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  c_nxt;
  logic              co_nxt;

  // Two-flop synchroniser plus a previous-level flop for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= {acc_btn, btn};
      s2   <= s1;
      prev <= s2;
    end
  end

  // Press pulses and hold/repeat expiry; the counter threshold depends on whether repeat is active.
  always_comb begin
    press = s2 & ~prev;
    for (int i = 0; i < 2; i++) begin
      fire[i] = s2[i] && (rpt[i] ? (cnt[i] == REPEAT_CYC - 24'd1)
                                 : (cnt[i] == HOLD_CYC - 24'd1));
    end
    evt = press[1:0] | fire;
  end

  // Hold counters run while the synchronised level is high; release clears everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      rpt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!s2[i]) begin
          cnt[i] <= '0;
          rpt[i] <= 1'b0;
        end else if (fire[i]) begin
          cnt[i] <= '0;
          rpt[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 24'd1;
        end
      end
    end
  end

  // Operand next-state: accumulate overrides a same-cycle A edit; B edits always apply.
  always_comb begin
    acc_fire = press[2] & mode;
    a_wr     = acc_fire | evt[0];
    b_wr     = evt[1];
    if (acc_fire) begin
      a_nxt = c;
    end else if (dir[0]) begin
      a_nxt = a - ONE;
    end else begin
      a_nxt = a + ONE;
    end
    b_nxt = dir[1] ? (b - ONE) : (b + ONE);
  end

  // Operand registers; wr_q remembers that an operand changed so res_valid lines up with the new c.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a         <= '0;
      b         <= '0;
      wr_q      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (a_wr) a <= a_nxt;
      if (b_wr) b <= b_nxt;
      wr_q      <= a_wr | b_wr;
      res_valid <= wr_q;
    end
  end

  // ALU combinational result; co is carry for add, no-borrow for sub, zero for logic ops.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    c_nxt  = '0;
    co_nxt = 1'b0;
    case (op)
      2'b00: {co_nxt, c_nxt} = sum;
      2'b01: begin
        c_nxt  = a - b;
        co_nxt = (a >= b);
      end
      2'b10: c_nxt = a & b;
      default: c_nxt = a | b;
    endcase
  end

  // Registered result stage, updated every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c    <= '0;
      co   <= 1'b0;
      zero <= 1'b1;
    end else begin
      c    <= c_nxt;
      co   <= co_nxt;
      zero <= (c_nxt == '0);
    end
  end

endmodule
